tag_fifo_serializer: RTL

//  Downstream stage of the pulse registration / time stamping block. Captures every
//  32-bit time-tag word issued with its one-cycle ready strobe and buffers it in a FIFO.

---
 rtl/tag_fifo_serializer.sv | 119 +++++++++++
 1 files changed

// File: rtl/tag_fifo_serializer.sv
// Time-tag word FIFO with an MSB-first byte serializer toward the host link.
// Words that arrive while the buffer is full are dropped and counted.
module tag_fifo_serializer #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              clear,
  input  logic [31:0]       in_data,
  input  logic              in_valid,
  output logic [7:0]        out_byte,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   fill,
  output logic              overflow,
  output logic [15:0]       drop_count
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned FILL_W = ADDR_W + 1;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [WORD_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [WORD_W-1:0]   word_q;
  logic [1:0]          byte_idx;

  logic                xfer;
  logic                last_xfer;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;
  logic                push_ok;
  logic                drop;

  // Handshake and FIFO control decisions for this cycle
  assign out_valid  = (state_q == S_SEND);
  assign out_byte   = word_q[WORD_W-1 -: BYTE_W];
  assign xfer       = out_valid && out_ready;
  assign last_xfer  = xfer && (byte_idx == 2'd3);
  assign fifo_full  = (fill == FILL_W'(DEPTH));
  assign fifo_empty = (fill == '0);
  assign pop        = ((state_q == S_IDLE) || last_xfer) && !fifo_empty;
  assign push_ok    = in_valid && (!fifo_full || pop);
  assign drop       = in_valid && !push_ok;

  // Serializer state register
  always_ff @(posedge clk or posedge clear) begin
    if (clear) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Serializer next state: load on pop, fall idle after the last byte if nothing is queued
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pop) state_d = S_SEND;
      S_SEND:  if (last_xfer && !pop) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Shifter: head word loads on pop, shifts one byte up on every transfer
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      word_q   <= '0;
      byte_idx <= '0;
    end else if (pop) begin
      word_q   <= mem[rd_ptr];
      byte_idx <= '0;
    end else if (xfer) begin
      word_q   <= {word_q[WORD_W-BYTE_W-1:0], BYTE_W'(0)};
      byte_idx <= byte_idx + 2'd1;
    end
  end

  // FIFO storage; no reset needed since fill gates every read
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= in_data;
  end

  // Pointers and occupancy; full/empty come from fill only
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push_ok, pop})
        2'b10:   fill <= fill + FILL_W'(1);
        2'b01:   fill <= fill - FILL_W'(1);
        default: fill <= fill;
      endcase
    end
  end

  // Loss accounting: sticky flag and saturating drop counter
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != {CNT_W{1'b1}}) drop_count <= drop_count + CNT_W'(1);
    end
  end

endmodule
